// File: rtl/aui_rx_pkg.sv
// Shared types for the RX flow combiner: block width, block pair payload and FSM states.
package aui_rx_pkg;

    localparam int unsigned BITS_BLOCK = 257;

    typedef logic [BITS_BLOCK-1:0] block_t;

    typedef struct packed {
        block_t f1;
        block_t f0;
    } block_pair_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EMIT_F0 = 2'd1,
        EMIT_F1 = 2'd2
    } state_e;

endpackage

// File: rtl/pair_fifo.sv
// Synchronous FIFO of block pairs; a push is still accepted when full if a pop happens in the same cycle.
module pair_fifo
    import aui_rx_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  block_pair_t             push_data,
    input  logic                    pop,
    output block_pair_t             head,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    block_pair_t   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          wr_en;
    logic          rd_en;

    always_comb begin
        rd_en    = pop && (count_q != '0);
        wr_en    = push && ((count_q != CW'(DEPTH)) || rd_en);
        wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(wr_en) - CW'(rd_en);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: pointers and count define validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/flow_combiner.sv
// Re-serialises descrambled flow_0/flow_1 block pairs into one ordered block stream.
module flow_combiner
    import aui_rx_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_valid,
    input  logic [BITS_BLOCK-1:0]   flow_0,
    input  logic [BITS_BLOCK-1:0]   flow_1,
    output logic [BITS_BLOCK-1:0]   data_out,
    output logic                    o_valid,
    output logic [$clog2(DEPTH):0]  o_fill,
    output logic                    o_overflow,
    output logic [CNT_WIDTH-1:0]    o_block_count
);

    localparam int unsigned FW = $clog2(DEPTH) + 1;

    state_e               state_q, state_d;
    block_t               data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ovf_q, ovf_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    block_pair_t   in_pair;
    block_pair_t   head;
    block_pair_t   src;
    logic          pop;
    logic          full;
    logic          empty;
    logic [FW-1:0] fill;

    pair_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (i_valid),
        .push_data (in_pair),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (fill)
    );

    always_comb begin
        in_pair.f0 = flow_0;
        in_pair.f1 = flow_1;
        state_d    = state_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        pop        = 1'b0;
        // An empty FIFO in IDLE forwards the incoming pair directly.
        src        = empty ? in_pair : head;
        case (state_q)
            IDLE: begin
                if (!empty || i_valid) begin
                    data_d  = src.f0;
                    valid_d = 1'b1;
                    state_d = EMIT_F1;
                end
            end
            EMIT_F1: begin
                data_d  = head.f1;
                valid_d = 1'b1;
                pop     = 1'b1;
                // A push alongside a pop is always accepted, so it counts as a further pair.
                state_d = ((fill > FW'(1)) || i_valid) ? EMIT_F0 : IDLE;
            end
            EMIT_F0: begin
                data_d  = head.f0;
                valid_d = 1'b1;
                state_d = EMIT_F1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ovf_d = ovf_q | (i_valid & full & ~pop);
        cnt_d = cnt_q + CNT_WIDTH'(valid_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign data_out      = data_q;
    assign o_valid       = valid_q;
    assign o_fill        = fill;
    assign o_overflow    = ovf_q;
    assign o_block_count = cnt_q;

endmodule
